ika2151_regwr_sched: RTL and testbench
======================================

Name: ika2151_regwr_sched

Overview:
- Schedules CPU register writes into the operator/channel register shift-registers.
- Each slot-indexed register is visible for exactly one of the 32 timing-generator slots.
- Buffers bus writes in a small FIFO and issues each write as a one-cycle commit strobe in the slot that owns the target register.
- Sits between the bus interface and the register file; driven by the phi1 negative clock enable and the cycle-01 timing pulse.

Parameters:
- FIFO_DEPTH, 4, number of buffered writes (power of 2, 2..16).
- PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- i_EMUCLK  in  1  emulator master clock; the only clock.
- i_MRST_n  in  1  asynchronous active-low reset.
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable, active low. All state advances only on EMUCLK edges where this is 0.
- i_CYCLE_01  in  1  timing pulse, high for one phi1 cycle per 32-slot frame.
- i_WR_REQ  in  1  write request, sampled on enabled edges.
- i_WR_ADDR  in  8  register address.
- i_WR_DATA  in  8  register data.
- o_BUSY  out  1  FIFO non-empty or commit in flight.
- o_FULL  out  1  FIFO full.
- o_OVF  out  1  sticky: a write was dropped while full.
- o_REG_WR  out  1  commit strobe, one phi1 cycle wide.
- o_REG_ADDR  out  8  commit address.
- o_REG_DATA  out  8  commit data.
- o_TIMEOUT  out  1  sticky watchdog flag; see Optional Feature.

Behaviour:
- Reset (async, while i_MRST_n=0):
  - All outputs 0.
  - FIFO empty, pointers 0.
  - slot counter 0, slot_valid=0, FSM=IDLE.
  - A reset mid-operation discards every pending write; no partial strobe is emitted.
- Slot counter (5-bit), updated on enabled edges:
  - i_CYCLE_01=1: counter <= 1, slot_valid <= 1.
  - Otherwise: counter <= counter+1, wrapping 31 -> 0.
- Write classes, decoded from the FIFO head:
  - Global, addr 0x00-0x1F: no slot wait.
  - Channel, 0x20-0x3F: target when counter[2:0] == addr[2:0].
  - Operator, 0x40-0xFF: target when counter == addr[4:0].
- Push:
  - i_WR_REQ=1 is accepted if not full, or if full and a pop occurs on the same edge.
  - If neither holds, the write is dropped and o_OVF <= 1. o_OVF clears only on reset.
- FSM:
  - IDLE: if FIFO non-empty -> WAIT.
  - WAIT, global head: o_REG_WR <= 1, o_REG_ADDR/o_REG_DATA <= head, pop -> COMMIT.
  - WAIT, channel/operator head: requires slot_valid=1 and a target match on the current counter value. Then strobe, pop -> COMMIT. Otherwise stay in WAIT.
  - COMMIT: o_REG_WR <= 0. If FIFO non-empty -> WAIT, else -> IDLE.
- Latency and ordering:
  - Minimum 2 enabled edges from push to strobe (push edge, then WAIT decision).
  - Operator worst case is 33 edges after the head reaches WAIT.
  - At most one commit per 2 phi1 cycles.
  - Strict FIFO order; head-of-line blocking is intended.
- o_BUSY = FIFO non-empty OR FSM != IDLE, registered on enabled edges.
- o_FULL is registered on enabled edges and reflects occupancy after that edge's push/pop.
- Push and pop on the same edge: occupancy unchanged; both take effect.
- o_REG_ADDR/o_REG_DATA hold their last committed values between strobes.
- No state changes on edges where i_phi1_NCEN_n=1.

Optional Feature:
- Macro: IKA2151_REGWR_SCHED_TIMEOUT_EN.
- Enabled:
  - 7-bit watchdog counts enabled edges spent in WAIT; it clears on leaving WAIT.
  - On reaching 64, the head is popped without a strobe, o_TIMEOUT <= 1 (sticky until reset), and the FSM goes to COMMIT.
  - Covers lost i_CYCLE_01 sync.
- Disabled: WAIT holds indefinitely; o_TIMEOUT tied 0; no watchdog logic.

Test Plan:
- Reset then sync via i_CYCLE_01; push addr 0x08 data 0x5A -> o_REG_WR high 2 enabled edges after push with 0x08/0x5A; o_BUSY falls 1 edge after the strobe ends.
- Push addr 0x6D data 0x33 -> strobe only on the edge where counter==13; verify via a bench mirror counter; strobe is exactly one phi1 cycle wide.
- Push addr 0x2A data 0x11 when counter==3 -> strobe at counter==10 (first match of low bits 010 after WAIT); never a second strobe.
- FIFO_DEPTH=4: push 5 operator writes back-to-back with no matching slot -> o_FULL=1 after the 4th, 5th dropped, o_OVF=1; the 4 writes commit in order.
- Assert i_MRST_n=0 asynchronously mid-WAIT with 3 queued -> all outputs 0 immediately; after release, no strobes until a new push.
- Macro on, no i_CYCLE_01 ever, push 0x40 -> after 64 edges in WAIT: no strobe, o_TIMEOUT=1, o_BUSY returns 0. Macro off -> o_BUSY stays 1, o_TIMEOUT=0.

Source files
------------

// File: rtl/ika2151_regwr_sched.sv
// Register-write scheduler: buffers CPU writes and commits each one in the
// timing slot that owns its target register. Optional watchdog: IKA2151_REGWR_SCHED_TIMEOUT_EN.
module ika2151_regwr_sched #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic       i_EMUCLK,
  input  logic       i_MRST_n,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_01,
  input  logic       i_WR_REQ,
  input  logic [7:0] i_WR_ADDR,
  input  logic [7:0] i_WR_DATA,
  output logic       o_BUSY,
  output logic       o_FULL,
  output logic       o_OVF,
  output logic       o_REG_WR,
  output logic [7:0] o_REG_ADDR,
  output logic [7:0] o_REG_DATA,
  output logic       o_TIMEOUT
);

  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SLOT_W = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_cnt_nxt;
  logic              slot_valid;
  logic              slot_valid_nxt;
  logic [1:0]        state;
  logic [1:0]        state_nxt;

  logic              en;
  wr_t               head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              head_global;
  logic              head_chan;
  logic              slot_hit;
  logic              push;
  logic              pop;
  logic              busy_nxt;
  logic              full_nxt;
  logic              ovf_nxt;
  logic              reg_wr_nxt;
  logic [7:0]        reg_addr_nxt;
  logic [7:0]        reg_data_nxt;

`ifdef IKA2151_REGWR_SCHED_TIMEOUT_EN
  localparam int unsigned WDOG_W = 7;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_nxt;
  logic              timeout_nxt;
`endif

  assign en = ~i_phi1_NCEN_n;

  // Head decode: global registers commit at once, others wait for their slot.
  assign head        = fifo_mem[rd_ptr];
  assign head_global = (head.addr[7:5] == 3'b000);
  assign head_chan   = (head.addr[7:5] == 3'b001);
  assign slot_hit    = slot_valid &&
                       (head_chan ? (slot_cnt[2:0] == head.addr[2:0])
                                  : (slot_cnt == head.addr[4:0]));

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push      = i_WR_REQ && (!fifo_full || pop);
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  assign full_nxt  = (count_nxt == CNT_W'(FIFO_DEPTH));
  assign ovf_nxt   = o_OVF | (i_WR_REQ & ~push);
  assign busy_nxt  = !fifo_empty || (state != ST_IDLE);

  assign slot_cnt_nxt   = i_CYCLE_01 ? SLOT_W'(1) : slot_cnt + SLOT_W'(1);
  assign slot_valid_nxt = slot_valid | i_CYCLE_01;

  // Next-state and commit decision.
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    reg_wr_nxt   = 1'b0;
    reg_addr_nxt = o_REG_ADDR;
    reg_data_nxt = o_REG_DATA;
`ifdef IKA2151_REGWR_SCHED_TIMEOUT_EN
    wdog_nxt     = '0;
    timeout_nxt  = o_TIMEOUT;
`endif
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!fifo_empty && (head_global || slot_hit)) begin
          reg_wr_nxt   = 1'b1;
          reg_addr_nxt = head.addr;
          reg_data_nxt = head.data;
          pop          = 1'b1;
          state_nxt    = ST_COMMIT;
        end
`ifdef IKA2151_REGWR_SCHED_TIMEOUT_EN
        else begin
          // The 64th edge spent waiting drops the head silently.
          wdog_nxt = wdog + WDOG_W'(1);
          if (wdog_nxt == WDOG_W'(64)) begin
            pop         = !fifo_empty;
            timeout_nxt = 1'b1;
            wdog_nxt    = '0;
            state_nxt   = ST_COMMIT;
          end
        end
`endif
      end
      ST_COMMIT: begin
        state_nxt = fifo_empty ? ST_IDLE : ST_WAIT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control state and registered outputs; frozen while the phi1 enable is inactive.
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      slot_cnt   <= '0;
      slot_valid <= 1'b0;
      o_BUSY     <= 1'b0;
      o_FULL     <= 1'b0;
      o_OVF      <= 1'b0;
      o_REG_WR   <= 1'b0;
      o_REG_ADDR <= '0;
      o_REG_DATA <= '0;
`ifdef IKA2151_REGWR_SCHED_TIMEOUT_EN
      wdog       <= '0;
      o_TIMEOUT  <= 1'b0;
`endif
    end else if (en) begin
      state      <= state_nxt;
      count      <= count_nxt;
      slot_cnt   <= slot_cnt_nxt;
      slot_valid <= slot_valid_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      o_BUSY     <= busy_nxt;
      o_FULL     <= full_nxt;
      o_OVF      <= ovf_nxt;
      o_REG_WR   <= reg_wr_nxt;
      o_REG_ADDR <= reg_addr_nxt;
      o_REG_DATA <= reg_data_nxt;
`ifdef IKA2151_REGWR_SCHED_TIMEOUT_EN
      wdog       <= wdog_nxt;
      o_TIMEOUT  <= timeout_nxt;
`endif
    end
  end

  // Payload storage; occupancy is tracked by the pointers, so no reset needed.
  always_ff @(posedge i_EMUCLK) begin
    if (en && push) fifo_mem[wr_ptr] <= {i_WR_ADDR, i_WR_DATA};
  end

`ifndef IKA2151_REGWR_SCHED_TIMEOUT_EN
  assign o_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_ika2151_regwr_sched.sv
// Scoreboard bench for ika2151_regwr_sched: stimulus queues expected commits,
// a monitor pops and checks them against a mirrored slot counter.
module tb_ika2151_regwr_sched;

  logic       clk;
  logic       rst_n;
  logic       ncen;
  logic       cyc;
  logic       req;
  logic [7:0] addr;
  logic [7:0] data;
  logic       o_BUSY, o_FULL, o_OVF, o_REG_WR, o_TIMEOUT;
  logic [7:0] o_REG_ADDR, o_REG_DATA;

  ika2151_regwr_sched #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
    .i_EMUCLK      (clk),
    .i_MRST_n      (rst_n),
    .i_phi1_NCEN_n (ncen),
    .i_CYCLE_01    (cyc),
    .i_WR_REQ      (req),
    .i_WR_ADDR     (addr),
    .i_WR_DATA     (data),
    .o_BUSY        (o_BUSY),
    .o_FULL        (o_FULL),
    .o_OVF         (o_OVF),
    .o_REG_WR      (o_REG_WR),
    .o_REG_ADDR    (o_REG_ADDR),
    .o_REG_DATA    (o_REG_DATA),
    .o_TIMEOUT     (o_TIMEOUT)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   nstrobes = 0;
  int   ecnt = 0;
  logic [4:0] mcnt = '0, pcnt = '0, last_strobe_cnt = '0;
  logic mvalid = 1'b0, pvalid = 1'b0, prev_wr = 1'b0, rst_evt = 1'b0;
  logic [31:0] snap = '0;

  wire [31:0] outs = 32'({o_BUSY, o_FULL, o_OVF, o_REG_WR, o_REG_ADDR, o_REG_DATA, o_TIMEOUT});

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // phi1 enable active on every other EMUCLK rising edge
  initial begin
    ncen = 1'b1;
    forever @(negedge clk) ncen = ~ncen;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got %0d checks, required finish", n_total);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge rst_n) rst_evt = 1'b1;

  // Monitor: mirror slot counter, check every strobe and frozen outputs on idle edges.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mcnt = '0; mvalid = 1'b0; prev_wr = 1'b0;
        #1;
        snap = outs; rst_evt = 1'b0;
      end else if (!ncen) begin
        pcnt = mcnt; pvalid = mvalid;
        if (cyc) begin mcnt = 5'd1; mvalid = 1'b1; end
        else mcnt = mcnt + 5'd1;
        ecnt++;
        #1;
        if (o_REG_WR) begin
          chk("strobe_width", 32'(prev_wr), 32'd0);
          chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_t e;
            logic hit;
            e = sb.pop_front();
            chk("strobe_addr", 32'(o_REG_ADDR), 32'(e.addr));
            chk("strobe_data", 32'(o_REG_DATA), 32'(e.data));
            if (e.addr[7:5] == 3'b000) hit = 1'b1;
            else if (e.addr[7:5] == 3'b001) hit = pvalid && (pcnt[2:0] == e.addr[2:0]);
            else hit = pvalid && (pcnt == e.addr[4:0]);
            chk("strobe_slot", 32'(hit), 32'd1);
          end
          nstrobes++;
          last_strobe_cnt = pcnt;
        end
        prev_wr = o_REG_WR;
        snap = outs; rst_evt = 1'b0;
      end else begin
        #1;
        if (!rst_evt && rst_n) chk("hold_when_disabled", outs, snap);
        snap = outs; rst_evt = 1'b0;
      end
    end
  end

  task automatic en_edge();
    do @(posedge clk); while (ncen);
    #2;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d, input bit add);
    if (add) sb.push_back({a, d});
    req = 1'b1; addr = a; data = d;
    en_edge();
    req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b1;
    en_edge();
  endtask

  task automatic sync_pulse();
    cyc = 1'b1;
    en_edge();
    cyc = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget, input string name);
    int k = 0;
    while (nstrobes < target && k < budget) begin
      en_edge();
      k++;
    end
    chk(name, 32'(nstrobes), 32'(target));
  endtask

  initial begin
    int n0;
    logic [4:0] tgt;
    rst_n = 1'b0; cyc = 1'b0; req = 1'b0; addr = '0; data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", outs, 32'd0);
    chk("reset_busy", 32'(o_BUSY), 32'd0);
    rst_n = 1'b1;
    repeat (3) en_edge();
    chk("idle_busy", 32'(o_BUSY), 32'd0);
    chk("idle_wr", 32'(o_REG_WR), 32'd0);

    // Global write: strobe two edges after the push edge.
    sync_pulse();
    push(8'h08, 8'h5A, 1'b1);
    en_edge();
    chk("t1_wr_e1", 32'(o_REG_WR), 32'd0);
    chk("t1_busy_e1", 32'(o_BUSY), 32'd1);
    en_edge();
    chk("t1_wr_e2", 32'(o_REG_WR), 32'd1);
    chk("t1_addr", 32'(o_REG_ADDR), 32'h08);
    chk("t1_data", 32'(o_REG_DATA), 32'h5A);
    en_edge();
    chk("t1_wr_e3", 32'(o_REG_WR), 32'd0);
    chk("t1_busy_e3", 32'(o_BUSY), 32'd1);
    chk("t1_hold_addr", 32'(o_REG_ADDR), 32'h08);
    en_edge();
    chk("t1_busy_e4", 32'(o_BUSY), 32'd0);

    // Operator write to slot 13.
    push(8'h6D, 8'h33, 1'b1);
    wait_strobes(2, 45, "t2_strobe");
    chk("t2_slot", 32'(last_strobe_cnt), 32'd13);
    en_edge();
    chk("t2_width", 32'(o_REG_WR), 32'd0);

    // Channel write pushed at counter 3 lands at counter 10.
    begin
      int k = 0;
      while (mcnt != 5'd3 && k < 40) begin en_edge(); k++; end
    end
    push(8'h2A, 8'h11, 1'b1);
    wait_strobes(3, 40, "t3_strobe");
    chk("t3_slot", 32'(last_strobe_cnt), 32'd10);
    repeat (40) en_edge();
    chk("t3_single", 32'(nstrobes), 32'd3);

    // Fill while unsynced: four accepted, fifth dropped, then drain in order.
    do_reset();
    push(8'h41, 8'hA1, 1'b1);
    push(8'h43, 8'hA3, 1'b1);
    push(8'h45, 8'hA5, 1'b1);
    chk("t4_full_3", 32'(o_FULL), 32'd0);
    push(8'h47, 8'hA7, 1'b1);
    chk("t4_full_4", 32'(o_FULL), 32'd1);
    chk("t4_ovf_4", 32'(o_OVF), 32'd0);
    push(8'h49, 8'hA9, 1'b0);
    chk("t4_ovf_5", 32'(o_OVF), 32'd1);
    chk("t4_full_5", 32'(o_FULL), 32'd1);
    n0 = nstrobes;
    sync_pulse();
    chk("t4_no_early", 32'(nstrobes), 32'(n0));
    wait_strobes(n0 + 4, 20, "t4_drain");
    chk("t4_full_after", 32'(o_FULL), 32'd0);
    chk("t4_ovf_sticky", 32'(o_OVF), 32'd1);

    // Async reset mid-WAIT with three writes queued.
    tgt = mcnt - 5'd1;
    push({3'b010, tgt}, 8'h01, 1'b0);
    push({3'b010, tgt}, 8'h02, 1'b0);
    push({3'b010, tgt}, 8'h03, 1'b0);
    en_edge();
    chk("t5_busy_before", 32'(o_BUSY), 32'd1);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t5_rst_outputs", outs, 32'd0);
    chk("t5_rst_ovf", 32'(o_OVF), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    n0 = nstrobes;
    repeat (5) en_edge();
    sync_pulse();
    repeat (40) en_edge();
    chk("t5_no_strobe", 32'(nstrobes), 32'(n0));
    chk("t5_busy_after", 32'(o_BUSY), 32'd0);
    push(8'h10, 8'h77, 1'b1);
    wait_strobes(n0 + 1, 6, "t5_new_push");

    // Watchdog behaviour with no slot sync.
    do_reset();
    n0 = nstrobes;
    push(8'h40, 8'h55, 1'b0);
`ifdef IKA2151_REGWR_SCHED_TIMEOUT_EN
    repeat (64) en_edge();
    chk("t6_timeout_pre", 32'(o_TIMEOUT), 32'd0);
    en_edge();
    chk("t6_timeout", 32'(o_TIMEOUT), 32'd1);
    repeat (5) en_edge();
    chk("t6_busy_clear", 32'(o_BUSY), 32'd0);
    chk("t6_no_strobe", 32'(nstrobes), 32'(n0));
`else
    repeat (100) en_edge();
    chk("t6_busy_hold", 32'(o_BUSY), 32'd1);
    chk("t6_timeout_off", 32'(o_TIMEOUT), 32'd0);
    chk("t6_no_strobe", 32'(nstrobes), 32'(n0));
`endif
    do_reset();
    repeat (2) en_edge();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
